// File: rtl/fp_classify_arbiter.sv
// Round-robin arbiter sharing one FP classify datapath among NUM_REQ requesters.
// Package, classify datapath and arbiter top live together in this file.

package fp_classify_pkg;

  typedef enum logic [1:0] {
    FP16 = 2'd0,
    FP32 = 2'd1,
    FP64 = 2'd2
  } fp_format_e;

  typedef enum logic [9:0] {
    CLS_NEG_INF  = 10'h001,
    CLS_NEG_NORM = 10'h002,
    CLS_NEG_SUB  = 10'h004,
    CLS_NEG_ZERO = 10'h008,
    CLS_POS_ZERO = 10'h010,
    CLS_POS_SUB  = 10'h020,
    CLS_POS_NORM = 10'h040,
    CLS_POS_INF  = 10'h080,
    CLS_SNAN     = 10'h100,
    CLS_QNAN     = 10'h200
  } classmask_e;

  function automatic int fp_width(fp_format_e fmt);
    case (fmt)
      FP16:    return 16;
      FP64:    return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int fp_exp_bits(fp_format_e fmt);
    case (fmt)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int fp_man_bits(fp_format_e fmt);
    return fp_width(fmt) - fp_exp_bits(fmt) - 1;
  endfunction

endpackage

// Combinational classifier: one-hot class mask, zero when start_i is low.
module fp_classify
  import fp_classify_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32
) (
  input  logic                             start_i,
  input  logic [fp_width(FP_FORMAT)-1:0]   operand_i,
  output logic [9:0]                       class_o
);

  localparam int FP_WIDTH = fp_width(FP_FORMAT);
  localparam int EXP_BITS = fp_exp_bits(FP_FORMAT);
  localparam int MAN_BITS = fp_man_bits(FP_FORMAT);

  logic                w_sign;
  logic [EXP_BITS-1:0] w_exp;
  logic [MAN_BITS-1:0] w_man;

  assign w_sign = operand_i[FP_WIDTH-1];
  assign w_exp  = operand_i[FP_WIDTH-2 -: EXP_BITS];
  assign w_man  = operand_i[MAN_BITS-1:0];

  // The quiet bit is the mantissa MSB; NaN sign is deliberately ignored.
  always_comb begin
    class_o = '0;
    if (start_i) begin
      if (&w_exp) begin
        if (w_man == '0)          class_o = w_sign ? CLS_NEG_INF : CLS_POS_INF;
        else if (w_man[MAN_BITS-1]) class_o = CLS_QNAN;
        else                      class_o = CLS_SNAN;
      end else if (w_exp == '0) begin
        if (w_man == '0)          class_o = w_sign ? CLS_NEG_ZERO : CLS_POS_ZERO;
        else                      class_o = w_sign ? CLS_NEG_SUB : CLS_POS_SUB;
      end else begin
        class_o = w_sign ? CLS_NEG_NORM : CLS_POS_NORM;
      end
    end
  end

endmodule

module fp_classify_arbiter
  import fp_classify_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  parameter int         NUM_REQ   = 4,
  localparam int        FP_WIDTH  = fp_width(FP_FORMAT),
  localparam int        ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*FP_WIDTH-1:0] req_operand_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [ID_WIDTH-1:0]         rsp_id_o,
  output logic [9:0]                  rsp_class_o,
  output logic                        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              r_state;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [ID_WIDTH-1:0] r_id;
  logic [FP_WIDTH-1:0] r_operand;
  logic [ID_WIDTH-1:0] r_rsp_id;
  logic [9:0]          r_rsp_class;
  logic                r_rsp_valid;
  logic                r_busy;

  logic                w_arb_en;
  logic                w_found;
  logic [ID_WIDTH-1:0] w_idx;
  logic [ID_WIDTH-1:0] w_next_ptr;
  logic [FP_WIDTH-1:0] w_sel_operand;
  logic [9:0]          w_class;
  int                  w_cand;

  assign w_arb_en = (r_state == IDLE) || ((r_state == RESP) && rsp_ready_i);

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_cand = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (req_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_idx   = ID_WIDTH'(w_cand);
      end
    end
  end

  assign w_next_ptr    = (w_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_sel_operand = req_operand_i[int'(w_idx)*FP_WIDTH +: FP_WIDTH];

  always_comb begin
    req_ready_o = '0;
    if (!rst_i && w_arb_en && w_found) req_ready_o[w_idx] = 1'b1;
  end

  fp_classify #(
    .FP_FORMAT (FP_FORMAT)
  ) u_classify (
    .start_i   (r_state == EXEC),
    .operand_i (r_operand),
    .class_o   (w_class)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_operand   <= '0;
      r_rsp_id    <= '0;
      r_rsp_class <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          if (w_arb_en) begin
            if (w_found) begin
              r_operand   <= w_sel_operand;
              r_id        <= w_idx;
              r_rr_ptr    <= w_next_ptr;
              r_state     <= EXEC;
              r_rsp_valid <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_state     <= IDLE;
              r_rsp_valid <= 1'b0;
              r_busy      <= 1'b0;
            end
          end
        end
        EXEC: begin
          r_rsp_id    <= r_id;
          r_rsp_class <= w_class;
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_busy      <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_class_o = r_rsp_class;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_fp_classify_arbiter.sv
// Randomized and directed bench for fp_classify_arbiter against a
// transaction-level model (grant cycle + fixed two-cycle latency).

module tb_fp_classify_arbiter;
  import fp_classify_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   reqValid;
  logic [N-1:0]   reqReady;
  logic [N*W-1:0] reqOperand;
  logic           rspValid;
  logic           rspReady;
  logic [1:0]     rspId;
  logic [9:0]     rspClass;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Model: whether an operation is held, when it was granted, and its result.
  bit       mHasOp;
  int       mGrantCycle;
  int       mPtr;
  int       mExpId;
  int       mExpClass;
  bit       mClean;

  fp_classify_arbiter #(
    .FP_FORMAT (FP32),
    .NUM_REQ   (N)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (reqValid),
    .req_ready_o   (reqReady),
    .req_operand_i (reqOperand),
    .rsp_valid_o   (rspValid),
    .rsp_ready_i   (rspReady),
    .rsp_id_o      (rspId),
    .rsp_class_o   (rspClass),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", tag, cycle, actual, expected);
    end
  endtask

  // Reference classification from IEEE-754 single precision field values.
  function automatic int refClass(input logic [31:0] op);
    int sgn;
    int ex;
    int man;
    sgn = int'(op[31]);
    ex  = int'(op[30:23]);
    man = int'(op[22:0]);
    if (ex == 255 && man != 0) return (man >= 32'h400000) ? 32'h200 : 32'h100;
    if (ex == 255)             return sgn ? 32'h001 : 32'h080;
    if (ex == 0 && man == 0)   return sgn ? 32'h008 : 32'h010;
    if (ex == 0)               return sgn ? 32'h004 : 32'h020;
    return sgn ? 32'h002 : 32'h040;
  endfunction

  function automatic logic [31:0] randOp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v[30:23] = 8'h00;
      1: begin v[30:23] = 8'h00; v[22:0] = '0; end
      2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      3: begin v[30:23] = 8'hFF; v[22] = 1'b0; v[0] = 1'b1; end
      4: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] ops,
                               input logic rr, input bit doCheck);
    bit expValid;
    bit arb;
    bit found;
    int winner;
    int k;
    logic [N-1:0] expReady;
    rst        = r;
    reqValid   = v;
    reqOperand = ops;
    rspReady   = rr;
    #4;
    expValid = mHasOp && (cycle >= mGrantCycle + 2);
    arb      = !r && (!mHasOp || (expValid && rr));
    found    = 1'b0;
    winner   = 0;
    if (arb) begin
      for (int i = 0; i < N; i++) begin
        k = (mPtr + i) % N;
        if (!found && v[k]) begin
          found  = 1'b1;
          winner = k;
        end
      end
    end
    expReady = '0;
    if (found) expReady[winner] = 1'b1;
    if (doCheck) begin
      checkOutput("req_ready", 32'(reqReady), 32'(expReady));
      checkOutput("rsp_valid", 32'(rspValid), 32'(expValid));
      checkOutput("busy", 32'(busy), 32'(mHasOp));
      if (expValid) begin
        checkOutput("rsp_id", 32'(rspId), 32'(mExpId));
        checkOutput("rsp_class", 32'(rspClass), 32'(mExpClass));
      end else if (mClean) begin
        checkOutput("rsp_id_reset", 32'(rspId), 32'd0);
        checkOutput("rsp_class_reset", 32'(rspClass), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      mHasOp = 1'b0;
      mPtr   = 0;
      mClean = 1'b1;
    end else if (found) begin
      mHasOp      = 1'b1;
      mGrantCycle = cycle;
      mExpId      = winner;
      mExpClass   = refClass(ops[winner*W +: W]);
      mPtr        = (winner + 1) % N;
      mClean      = 1'b0;
    end else if (arb) begin
      mHasOp = 1'b0;
    end
    cycle++;
  endtask

  function automatic logic [N*W-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  initial begin
    logic [N*W-1:0] ops;
    mHasOp = 1'b0; mGrantCycle = 0; mPtr = 0; mExpId = 0; mExpClass = 0; mClean = 1'b1;
    ops = '0;
    applyStimulus(1'b1, '0, ops, 1'b1, 1'b0);
    applyStimulus(1'b1, '0, ops, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, ops, 1'b1, 1'b1);

    $display("[TB] single request");
    ops = pack4(32'h3F800000, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 4'b0001, ops, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b0000, ops, 1'b1, 1'b1);

    $display("[TB] all requesters, then wrap");
    applyStimulus(1'b1, '0, ops, 1'b1, 1'b1);
    ops = pack4(32'hFF800000, 32'h80000000, 32'h00000001, 32'h7FC00000);
    repeat (7) applyStimulus(1'b0, 4'b1111, ops, 1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 4'b0110, ops, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b0000, ops, 1'b1, 1'b1);

    $display("[TB] backpressure");
    ops = pack4(32'h7F800001, 32'h0, 32'h3F800000, 32'h0);
    applyStimulus(1'b0, 4'b0001, ops, 1'b0, 1'b1);
    repeat (7) applyStimulus(1'b0, 4'b0100, ops, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0100, ops, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 4'b0000, ops, 1'b1, 1'b1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 4'b0010, ops, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0000, ops, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b0000, ops, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b1111, ops, 1'b1, 1'b1);

    $display("[TB] idle");
    repeat (10) applyStimulus(1'b0, 4'b0000, ops, 1'b1, 1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      ops = pack4(randOp(), randOp(), randOp(), randOp());
      applyStimulus(($urandom_range(0, 59) == 0), 4'($urandom), ops,
                    ($urandom_range(0, 3) != 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
